gpu_pixel_writer: RTL and testbench

GPU_PIXEL_WRITER -- requirements
Module: gpu_pixel_writer

---
 rtl/gpu_pixel_writer.sv | 102 ++++++++++
 tb/tb_gpu_pixel_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_pixel_writer.sv
// Pixel writer: queues rasterizer pixels as {address, color} and drains them
// into SRAM one word per cycle whenever the display is not using the bus.
module gpu_pixel_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 400
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_VIDEO_ON,
  input  logic        I_PIX_VALID,
  input  logic [9:0]  I_PIX_X,
  input  logic [9:0]  I_PIX_Y,
  input  logic [11:0] I_PIX_COLOR,
  output logic        O_PIX_READY,
  output logic [17:0] O_GPU_ADDR,
  output logic [15:0] O_GPU_DATA,
  output logic        O_GPU_WRITE,
  output logic        O_GPU_READ,
  output logic        O_GPUStallSignal,
  output logic [15:0] O_DROP_CNT,
  output logic        O_IDLE
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [10:0]      FBW_C   = 11'(FB_WIDTH);
  localparam logic [10:0]      FBH_C   = 11'(FB_HEIGHT);
  localparam logic [17:0]      FBW18_C = 18'(FB_WIDTH);

  logic [29:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             push_acc;
  logic             in_bounds;
  logic             enq;
  logic             drop;
  logic             pop;
  logic [17:0]      pix_addr;
  logic [29:0]      rd_entry;

  // Handshake: a pixel is consumed on a rising edge where I_PIX_VALID and
  // O_PIX_READY are both 1. Ready depends only on registered occupancy and
  // reset, never on valid, so a full queue stays not-ready for the whole cycle.
  assign O_PIX_READY      = I_RST_N && (count < DEPTH_C);
  assign O_GPUStallSignal = ~O_PIX_READY;
  assign O_GPU_READ       = 1'b0;
  assign O_IDLE           = !I_RST_N || ((count == '0) && !O_GPU_WRITE);

  always_comb begin
    push_acc  = I_PIX_VALID && O_PIX_READY;
    in_bounds = ({1'b0, I_PIX_X} < FBW_C) && ({1'b0, I_PIX_Y} < FBH_C);
    enq       = push_acc && in_bounds;
    drop      = push_acc && !in_bounds;
    pop       = !I_VIDEO_ON && (count != '0);
    pix_addr  = ({8'd0, I_PIX_Y} * FBW18_C) + {8'd0, I_PIX_X};
    rd_entry  = mem[rd_ptr];
  end

  // Storage has no reset; validity is tracked entirely by count and pointers.
  always_ff @(posedge I_CLK) begin
    if (enq) begin
      mem[wr_ptr] <= {pix_addr, I_PIX_COLOR};
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RST_N) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      O_GPU_ADDR  <= '0;
      O_GPU_DATA  <= '0;
      O_GPU_WRITE <= 1'b0;
      O_DROP_CNT  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PTR_W'(1);
        O_GPU_ADDR  <= rd_entry[29:12];
        O_GPU_DATA  <= {4'h0, rd_entry[11:0]};
        O_GPU_WRITE <= 1'b1;
      end else begin
        O_GPU_WRITE <= 1'b0;
      end
      case ({enq, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop && (O_DROP_CNT != 16'hFFFF)) begin
        O_DROP_CNT <= O_DROP_CNT + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
// Directed bench for gpu_pixel_writer: SRAM writes are matched in order
// against an expected queue of {addr, data} built as pixels are accepted.
module tb_gpu_pixel_writer;

  logic        I_CLK;
  logic        I_RST_N;
  logic        I_VIDEO_ON;
  logic        I_PIX_VALID;
  logic [9:0]  I_PIX_X;
  logic [9:0]  I_PIX_Y;
  logic [11:0] I_PIX_COLOR;
  logic        O_PIX_READY;
  logic [17:0] O_GPU_ADDR;
  logic [15:0] O_GPU_DATA;
  logic        O_GPU_WRITE;
  logic        O_GPU_READ;
  logic        O_GPUStallSignal;
  logic [15:0] O_DROP_CNT;
  logic        O_IDLE;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int wr_base  = 0;
  int exp_drops = 0;
  logic [33:0] exp_q[$];

  gpu_pixel_writer #(
    .FIFO_DEPTH(8),
    .FB_WIDTH(640),
    .FB_HEIGHT(400)
  ) dut (
    .I_CLK(I_CLK),
    .I_RST_N(I_RST_N),
    .I_VIDEO_ON(I_VIDEO_ON),
    .I_PIX_VALID(I_PIX_VALID),
    .I_PIX_X(I_PIX_X),
    .I_PIX_Y(I_PIX_Y),
    .I_PIX_COLOR(I_PIX_COLOR),
    .O_PIX_READY(O_PIX_READY),
    .O_GPU_ADDR(O_GPU_ADDR),
    .O_GPU_DATA(O_GPU_DATA),
    .O_GPU_WRITE(O_GPU_WRITE),
    .O_GPU_READ(O_GPU_READ),
    .O_GPUStallSignal(O_GPUStallSignal),
    .O_DROP_CNT(O_DROP_CNT),
    .O_IDLE(O_IDLE)
  );

  // clock / reset
  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // scoreboard: every SRAM write must match the oldest expected entry
  always @(negedge I_CLK) begin
    if (O_GPU_WRITE === 1'b1) begin
      logic [33:0] e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'd0, O_GPU_WRITE}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {14'd0, O_GPU_ADDR}, {14'd0, e[33:16]});
        check("wr_data", {16'd0, O_GPU_DATA}, {16'd0, e[15:0]});
      end
    end
  end

  // driver: offer one pixel, wait (bounded) for ready, return at the next negedge
  task automatic push_px(input int x, input int y, input logic [11:0] c);
    int waited;
    int addr;
    waited      = 0;
    I_PIX_VALID = 1'b1;
    I_PIX_X     = x[9:0];
    I_PIX_Y     = y[9:0];
    I_PIX_COLOR = c;
    while (!O_PIX_READY && waited < 100) begin
      @(negedge I_CLK);
      waited++;
    end
    if (!O_PIX_READY) begin
      check("push_timeout", {31'd0, O_PIX_READY}, 32'd1);
      I_PIX_VALID = 1'b0;
      return;
    end
    @(posedge I_CLK);
    if (x < 640 && y < 400) begin
      addr = y * 640 + x;
      exp_q.push_back({addr[17:0], 4'h0, c});
    end else begin
      exp_drops++;
    end
    @(negedge I_CLK);
    I_PIX_VALID = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge I_CLK);
  endtask

  initial begin
    I_RST_N     = 1'b0;
    I_VIDEO_ON  = 1'b0;
    I_PIX_VALID = 1'b0;
    I_PIX_X     = '0;
    I_PIX_Y     = '0;
    I_PIX_COLOR = '0;

    // reset state
    idle_cycles(3);
    check("rst_ready", {31'd0, O_PIX_READY}, 32'd0);
    check("rst_stall", {31'd0, O_GPUStallSignal}, 32'd1);
    check("rst_idle", {31'd0, O_IDLE}, 32'd1);
    check("rst_write", {31'd0, O_GPU_WRITE}, 32'd0);
    check("rst_addr", {14'd0, O_GPU_ADDR}, 32'd0);
    check("rst_data", {16'd0, O_GPU_DATA}, 32'd0);
    check("rst_drop", {16'd0, O_DROP_CNT}, 32'd0);
    check("rst_read", {31'd0, O_GPU_READ}, 32'd0);
    I_RST_N = 1'b1;
    @(negedge I_CLK);
    check("post_rst_ready", {31'd0, O_PIX_READY}, 32'd1);
    check("post_rst_stall", {31'd0, O_GPUStallSignal}, 32'd0);

    // single pixel: one write exactly one edge after acceptance
    push_px(5, 2, 12'hF00);
    check("single_not_bypassed", {31'd0, O_GPU_WRITE}, 32'd0);
    @(negedge I_CLK);
    check("single_write", {31'd0, O_GPU_WRITE}, 32'd1);
    check("single_addr", {14'd0, O_GPU_ADDR}, 32'd1285);
    check("single_data", {16'd0, O_GPU_DATA}, 32'h0F00);
    @(negedge I_CLK);
    check("single_write_off", {31'd0, O_GPU_WRITE}, 32'd0);
    check("single_addr_hold", {14'd0, O_GPU_ADDR}, 32'd1285);
    check("single_idle", {31'd0, O_IDLE}, 32'd1);

    // fill under video, then refused offers, then drain
    wr_base    = wr_cnt;
    I_VIDEO_ON = 1'b1;
    for (int i = 0; i < 8; i++) push_px(10 + i, 3, 12'h100 + 12'(i));
    check("fill_ready", {31'd0, O_PIX_READY}, 32'd0);
    check("fill_stall", {31'd0, O_GPUStallSignal}, 32'd1);
    check("fill_idle", {31'd0, O_IDLE}, 32'd0);
    I_PIX_VALID = 1'b1;
    I_PIX_X     = 10'd1;
    I_PIX_Y     = 10'd1;
    I_PIX_COLOR = 12'hEEE;
    idle_cycles(3);
    I_PIX_VALID = 1'b0;
    check("fill_no_write", wr_cnt - wr_base, 32'd0);
    check("fill_ready_held", {31'd0, O_PIX_READY}, 32'd0);
    I_VIDEO_ON = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge I_CLK);
      check("fill_drain_write", {31'd0, O_GPU_WRITE}, 32'd1);
      if (i == 0) check("fill_ready_after_pop", {31'd0, O_PIX_READY}, 32'd1);
    end
    @(negedge I_CLK);
    check("fill_done_write", {31'd0, O_GPU_WRITE}, 32'd0);
    check("fill_done_idle", {31'd0, O_IDLE}, 32'd1);
    check("fill_write_count", wr_cnt - wr_base, 32'd8);

    // bounds
    wr_base = wr_cnt;
    push_px(640, 0, 12'h111);
    push_px(0, 400, 12'h222);
    push_px(639, 399, 12'hABC);
    idle_cycles(3);
    check("bounds_drop_cnt", {16'd0, O_DROP_CNT}, 32'd2);
    check("bounds_drop_model", {16'd0, O_DROP_CNT}, exp_drops);
    check("bounds_write_count", wr_cnt - wr_base, 32'd1);
    check("bounds_last_addr", {14'd0, O_GPU_ADDR}, 32'd255999);
    check("bounds_last_data", {16'd0, O_GPU_DATA}, 32'h0ABC);

    // streaming: continuous valid, one write per cycle
    wr_base = wr_cnt;
    for (int i = 0; i < 10; i++) begin
      check("stream_ready", {31'd0, O_PIX_READY}, 32'd1);
      if (i >= 2) check("stream_write", {31'd0, O_GPU_WRITE}, 32'd1);
      push_px(100 + i, 50 + i, 12'h300 + 12'(i));
    end
    idle_cycles(3);
    check("stream_write_count", wr_cnt - wr_base, 32'd10);
    check("stream_idle", {31'd0, O_IDLE}, 32'd1);

    // video-on interrupt after two writes
    wr_base    = wr_cnt;
    I_VIDEO_ON = 1'b1;
    for (int i = 0; i < 4; i++) push_px(200, 10 + i, 12'h0A0 + 12'(i));
    I_VIDEO_ON = 1'b0;
    @(negedge I_CLK);
    check("intr_write1", {31'd0, O_GPU_WRITE}, 32'd1);
    @(negedge I_CLK);
    check("intr_write2", {31'd0, O_GPU_WRITE}, 32'd1);
    I_VIDEO_ON = 1'b1;
    @(negedge I_CLK);
    check("intr_stopped", {31'd0, O_GPU_WRITE}, 32'd0);
    idle_cycles(3);
    check("intr_held", {31'd0, O_GPU_WRITE}, 32'd0);
    check("intr_not_idle", {31'd0, O_IDLE}, 32'd0);
    I_VIDEO_ON = 1'b0;
    @(negedge I_CLK);
    check("intr_write3", {31'd0, O_GPU_WRITE}, 32'd1);
    @(negedge I_CLK);
    check("intr_write4", {31'd0, O_GPU_WRITE}, 32'd1);
    @(negedge I_CLK);
    check("intr_done_idle", {31'd0, O_IDLE}, 32'd1);
    check("intr_write_count", wr_cnt - wr_base, 32'd4);

    // reset mid-drain
    I_VIDEO_ON = 1'b1;
    for (int i = 0; i < 5; i++) push_px(300 + i, 20, 12'h5A0 + 12'(i));
    I_VIDEO_ON = 1'b0;
    @(negedge I_CLK);
    #1;
    I_RST_N = 1'b0;
    exp_q.delete();
    wr_base = wr_cnt;
    @(negedge I_CLK);
    check("mid_rst_write", {31'd0, O_GPU_WRITE}, 32'd0);
    check("mid_rst_addr", {14'd0, O_GPU_ADDR}, 32'd0);
    check("mid_rst_data", {16'd0, O_GPU_DATA}, 32'd0);
    check("mid_rst_drop", {16'd0, O_DROP_CNT}, 32'd0);
    check("mid_rst_ready", {31'd0, O_PIX_READY}, 32'd0);
    check("mid_rst_stall", {31'd0, O_GPUStallSignal}, 32'd1);
    check("mid_rst_idle", {31'd0, O_IDLE}, 32'd1);
    @(negedge I_CLK);
    I_RST_N = 1'b1;
    idle_cycles(5);
    check("mid_rst_no_stale", wr_cnt - wr_base, 32'd0);
    check("mid_rst_ready_after", {31'd0, O_PIX_READY}, 32'd1);
    check("mid_rst_idle_after", {31'd0, O_IDLE}, 32'd1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
